// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
package cache_pkg;

   localparam int STATS_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      MEM_RD,
      MEM_WAIT,
      MEM_WR
   } state_e;

   function automatic int tag_bits(input int addlength, input int indexbits);
      return addlength - indexbits;
   endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid/tag/data arrays for the cache lines: asynchronous read by index,
// one synchronous write port with a separate valid-set strobe, valid bits cleared on rst.
module cache_tag_store #(
   parameter int INDEXBITS  = 6,
   parameter int TAGBITS    = 10,
   parameter int DATALENGTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEXBITS-1:0]  rd_idx_i,
   output logic                  rd_valid_o,
   output logic [TAGBITS-1:0]    rd_tag_o,
   output logic [DATALENGTH-1:0] rd_data_o,
   input  logic                  wr_en_i,
   input  logic                  valid_set_i,
   input  logic [INDEXBITS-1:0]  wr_idx_i,
   input  logic [TAGBITS-1:0]    wr_tag_i,
   input  logic [DATALENGTH-1:0] wr_data_i
);
   localparam int LINES = 1 << INDEXBITS;

   logic [LINES-1:0]      valid_q;
   logic [TAGBITS-1:0]    tag_q  [LINES];
   logic [DATALENGTH-1:0] data_q [LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en_i && valid_set_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // A reset edge must never land a half-finished fill in the arrays.
   always_ff @(posedge clk) begin
      if (wr_en_i && !rst) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller between CPU and RAM.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_ctrl import cache_pkg::*; #(
   parameter int ADDLENGTH  = 16,
   parameter int DATALENGTH = 32,
   parameter int INDEXBITS  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDLENGTH-1:0]  cpu_addr,
   input  logic [DATALENGTH-1:0] cpu_wdata,
   input  logic                  cpu_rd,
   input  logic                  cpu_wr,
   output logic [DATALENGTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   output logic                  cpu_busy,
   output logic [ADDLENGTH-1:0]  mem_addr,
   output logic [DATALENGTH-1:0] mem_datain,
   input  logic [DATALENGTH-1:0] mem_dataout,
   output logic                  mem_RE,
   output logic                  mem_WE
`ifdef CACHE_STATS_EN
   ,
   output logic [STATS_W-1:0]    hit_count,
   output logic [STATS_W-1:0]    miss_count
`endif
);
   localparam int TAGBITS = tag_bits(ADDLENGTH, INDEXBITS);

   state_e                state_q, state_d;
   logic [ADDLENGTH-1:0]  req_addr_q, req_addr_d;
   logic [DATALENGTH-1:0] req_wdata_q, req_wdata_d;
   logic                  req_wr_q, req_wr_d;
   logic [DATALENGTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic                  cpu_ready_q, cpu_ready_d;
   logic [ADDLENGTH-1:0]  mem_addr_q, mem_addr_d;
   logic [DATALENGTH-1:0] mem_datain_q, mem_datain_d;
   logic                  mem_re_q, mem_re_d;
   logic                  mem_we_q, mem_we_d;

   logic                  line_valid;
   logic [TAGBITS-1:0]    line_tag;
   logic [DATALENGTH-1:0] line_data;
   logic                  line_wr;
   logic                  line_valid_set;
   logic [DATALENGTH-1:0] line_wdata;
   logic [INDEXBITS-1:0]  req_idx;
   logic [TAGBITS-1:0]    req_tag;
   logic                  hit;

   assign req_idx = req_addr_q[INDEXBITS-1:0];
   assign req_tag = req_addr_q[ADDLENGTH-1:INDEXBITS];
   assign hit     = line_valid && (line_tag == req_tag);

   cache_tag_store #(
      .INDEXBITS  (INDEXBITS),
      .TAGBITS    (TAGBITS),
      .DATALENGTH (DATALENGTH)
   ) u_tag_store (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (req_idx),
      .rd_valid_o  (line_valid),
      .rd_tag_o    (line_tag),
      .rd_data_o   (line_data),
      .wr_en_i     (line_wr),
      .valid_set_i (line_valid_set),
      .wr_idx_i    (req_idx),
      .wr_tag_i    (req_tag),
      .wr_data_i   (line_wdata)
   );

   always_comb begin
      state_d        = state_q;
      req_addr_d     = req_addr_q;
      req_wdata_d    = req_wdata_q;
      req_wr_d       = req_wr_q;
      cpu_rdata_d    = cpu_rdata_q;
      cpu_ready_d    = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_datain_d   = mem_datain_q;
      mem_re_d       = mem_re_q;
      mem_we_d       = mem_we_q;
      line_wr        = 1'b0;
      line_valid_set = 1'b0;
      line_wdata     = req_wdata_q;
      unique case (state_q)
         IDLE: begin
            // A simultaneous load and store collapses to the store.
            if (cpu_wr || cpu_rd) begin
               req_addr_d  = cpu_addr;
               req_wdata_d = cpu_wdata;
               req_wr_d    = cpu_wr;
               state_d     = COMPARE;
            end
         end
         COMPARE: begin
            if (req_wr_q) begin
               mem_addr_d   = req_addr_q;
               mem_datain_d = req_wdata_q;
               mem_we_d     = 1'b1;
               line_wr      = hit;
               state_d      = MEM_WR;
            end else if (hit) begin
               cpu_rdata_d = line_data;
               cpu_ready_d = 1'b1;
               state_d     = IDLE;
            end else begin
               mem_addr_d = req_addr_q;
               mem_re_d   = 1'b1;
               state_d    = MEM_RD;
            end
         end
         MEM_RD: begin
            mem_re_d = 1'b0;
            state_d  = MEM_WAIT;
         end
         MEM_WAIT: begin
            line_wr        = 1'b1;
            line_valid_set = 1'b1;
            line_wdata     = mem_dataout;
            cpu_rdata_d    = mem_dataout;
            cpu_ready_d    = 1'b1;
            state_d        = IDLE;
         end
         MEM_WR: begin
            mem_we_d    = 1'b0;
            cpu_ready_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         req_wr_q     <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_ready_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_datain_q <= '0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_wr_q     <= req_wr_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_ready_q  <= cpu_ready_d;
         mem_addr_q   <= mem_addr_d;
         mem_datain_q <= mem_datain_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
      end
   end

   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_ready  = cpu_ready_q;
   assign cpu_busy   = (state_q != IDLE);
   assign mem_addr   = mem_addr_q;
   assign mem_datain = mem_datain_q;
   assign mem_RE     = mem_re_q;
   assign mem_WE     = mem_we_q;

`ifdef CACHE_STATS_EN
   logic [STATS_W-1:0] hit_count_q, miss_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else if (state_q == COMPARE) begin
         if (hit && hit_count_q != '1) begin
            hit_count_q <= hit_count_q + 1'b1;
         end else if (!hit && miss_count_q != '1) begin
            miss_count_q <= miss_count_q + 1'b1;
         end
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`else
   // Without statistics, the hit decode feeds only the FSM.
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl against a line-level cache/memory model.
// Build with CACHE_STATS_EN defined to also check hit_count/miss_count.
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_rd = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        cpu_busy;
   logic [15:0] mem_addr;
   logic [31:0] mem_datain;
   logic [31:0] mem_dataout = '0;
   logic        mem_RE;
   logic        mem_WE;
`ifdef CACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rd      (cpu_rd),
      .cpu_wr      (cpu_wr),
      .cpu_rdata   (cpu_rdata),
      .cpu_ready   (cpu_ready),
      .cpu_busy    (cpu_busy),
      .mem_addr    (mem_addr),
      .mem_datain  (mem_datain),
      .mem_dataout (mem_dataout),
      .mem_RE      (mem_RE),
      .mem_WE      (mem_WE)
`ifdef CACHE_STATS_EN
      ,
      .hit_count   (hit_count),
      .miss_count  (miss_count)
`endif
   );

   function automatic logic [31:0] ram_init(input logic [15:0] a);
      if (a == 16'h0041) return 32'hDEADBEEF;
      return ({16'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Synchronous RAM: unwritten words read their power-on pattern.
   logic [31:0] ram     [65536];
   bit          wr_mask [65536];
   always @(posedge clk) begin
      if (mem_WE) begin
         ram[mem_addr]     <= mem_datain;
         wr_mask[mem_addr] <= 1'b1;
      end
      if (mem_RE) mem_dataout <= wr_mask[mem_addr] ? ram[mem_addr] : ram_init(mem_addr);
   end

   bit overlap_seen = 1'b0;
   always @(negedge clk) if (mem_RE && mem_WE) overlap_seen <= 1'b1;

   // Reference model: memory image plus which tag each line currently holds.
   logic [31:0] ref_mem [65536];
   bit          m_valid [64];
   logic [9:0]  m_tag   [64];
   logic [31:0] last_load = '0;
   int          m_hits = 0;
   int          m_misses = 0;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_stats();
`ifdef CACHE_STATS_EN
      check("hit_count", {16'h0, hit_count}, 32'(m_hits));
      check("miss_count", {16'h0, miss_count}, 32'(m_misses));
`endif
   endtask

   // Issue one request from #1 after an edge and follow it to completion.
   task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                         input logic [31:0] wd, input bit gap_chk);
      int          cyc, re_n, we_n, exp_lat;
      bit          done, is_hit;
      logic [5:0]  idx;
      logic [9:0]  tg;
      idx     = a[5:0];
      tg      = a[15:6];
      is_hit  = m_valid[idx] && (m_tag[idx] == tg);
      exp_lat = wr ? 3 : (is_hit ? 2 : 4);
      cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
      cyc = 0; re_n = 0; we_n = 0; done = 1'b0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         cpu_rd = 1'b0; cpu_wr = 1'b0;
         if (mem_RE) re_n++;
         if (mem_WE) we_n++;
         if (cpu_ready) done = 1'b1;
      end
      check("completed", 32'(done), 32'd1);
      check("latency", 32'(cyc), 32'(exp_lat));
      if (is_hit) m_hits++; else m_misses++;
      if (wr) begin
         ref_mem[a] = wd;
         check("st_re_cycles", 32'(re_n), 32'd0);
         check("st_we_cycles", 32'(we_n), 32'd1);
         check("ram_written", ram[a], wd);
         check("rdata_hold", cpu_rdata, last_load);
      end else begin
         check("ld_re_cycles", 32'(re_n), is_hit ? 32'd0 : 32'd1);
         check("ld_we_cycles", 32'(we_n), 32'd0);
         check("ld_data", cpu_rdata, ref_mem[a]);
         last_load = ref_mem[a];
         if (!is_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
         end
      end
      check_stats();
      $display("txn %s addr=%h wdata=%h %s cycles=%0d rdata=%h",
               wr ? "st" : "ld", a, wd, is_hit ? "hit" : "miss", cyc, cpu_rdata);
      if (gap_chk) begin
         @(posedge clk); #1;
         check("ready_one_cycle", 32'(cpu_ready), 32'd0);
         check("idle_not_busy", 32'(cpu_busy), 32'd0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 32'(cpu_ready), 32'd0);
      check({tag, "_busy"}, 32'(cpu_busy), 32'd0);
      check({tag, "_rdata"}, cpu_rdata, 32'd0);
      check({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'd0);
      check({tag, "_mem_datain"}, mem_datain, 32'd0);
      check({tag, "_mem_re"}, 32'(mem_RE), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_WE), 32'd0);
   endtask

   initial begin
      int rdy_n, re_n, we_n;
      for (int i = 0; i < 65536; i++) ref_mem[i] = ram_init(16'(i));
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
      end

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_all_zero("reset");
      check_stats();

      // Cold load, hit, store hit, store miss without allocate, eviction.
      do_req(1'b1, 1'b0, 16'h0041, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 16'h0041, 32'h0, 1'b1);
      do_req(1'b0, 1'b1, 16'h0041, 32'h12345678, 1'b1);
      do_req(1'b1, 1'b0, 16'h0041, 32'h0, 1'b1);
      do_req(1'b0, 1'b1, 16'h0081, 32'hCAFEF00D, 1'b1);
      do_req(1'b1, 1'b0, 16'h0041, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 16'h0081, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 16'h0041, 32'h0, 1'b1);

      // Back-to-back: the second request is presented in the ready cycle.
      do_req(1'b1, 1'b0, 16'h0041, 32'h0, 1'b0);
      do_req(1'b1, 1'b0, 16'h0081, 32'h0, 1'b1);

      // Load and store together, then a load pulsed while busy.
      cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 32'hA5A50042;
      rdy_n = 0; re_n = 0; we_n = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h7705;
         end else begin
            cpu_rd = 1'b0;
         end
         if (cpu_ready) rdy_n++;
         if (mem_RE) re_n++;
         if (mem_WE) we_n++;
      end
      if (m_valid[2] && m_tag[2] == 10'h001) m_hits++; else m_misses++;
      ref_mem[16'h0042] = 32'hA5A50042;
      check("prio_ready_pulses", 32'(rdy_n), 32'd1);
      check("prio_re_cycles", 32'(re_n), 32'd0);
      check("prio_we_cycles", 32'(we_n), 32'd1);
      check("prio_ram", ram[16'h0042], 32'hA5A50042);
      check("prio_rdata_hold", cpu_rdata, last_load);
      check_stats();
      $display("txn st+ld addr=0042 wdata=a5a50042 busy-load addr=7705 readies=%0d", rdy_n);

      // Reset while the miss is waiting on RAM data.
      cpu_rd = 1'b1; cpu_addr = 16'h1234;
      @(posedge clk); #1 cpu_rd = 1'b0;
      @(posedge clk); #1;
      check("midrst_re_high", 32'(mem_RE), 32'd1);
      @(posedge clk); #1;
      check("midrst_wait_busy", 32'(cpu_busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check_all_zero("midrst");
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      last_load = '0;
      m_hits = 0;
      m_misses = 0;
      check_stats();
      $display("txn reset during miss addr=1234");
      do_req(1'b1, 1'b0, 16'h1234, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 16'h0041, 32'h0, 1'b1);

      // Random mix over a few tags per index to exercise hits and evictions.
      for (int n = 0; n < 150; n++) begin
         logic [15:0] a;
         int          op;
         a  = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
         op = int'($urandom_range(0, 9));
         do_req(op < 6 || op == 9, op >= 6, a, $urandom, $urandom_range(0, 1) == 1);
      end
      @(posedge clk); #1;

      check("re_we_exclusive", 32'(overlap_seen), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
